pipe_wb: RTL and testbench
==========================

// Module: pipe_wb
// PURPOSE
//  MEM/WB pipeline register plus writeback stage of the 5-stage MIPS pipeline.
//  Producer side of the register-file write port: drives wwreg/wGPR/RF_indata,
//  which the ID stage consumes for the RF write and for forwarding.
//  Adds sub-word load alignment and a wait-state handshake for a slow data
//  memory, stalling upstream stages until load data is valid.
// PARAMETERS
//  TIMEOUT   16  max cycles to wait for dm_ready before forcing load completion
//  CNT_W     5   width of the wait counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1   pipeline clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  mwreg      in   1   M-stage instruction writes a GPR
//  mm2reg     in   1   M-stage instruction is a load (data from DM)
//  mGPR       in   5   M-stage destination register number
//  malu       in   32  M-stage ALU result / load effective address
//  mmo        in   32  raw aligned word read from DM
//  mltype     in   3   load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
//  dm_ready   in   1   DM read data valid this cycle
//  wwreg      out  1   RF write enable
//  wGPR       out  5   RF write register number
//  RF_indata  out  32  RF write data
//  wb_stall   out  1   freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//  dm_err     out  1   sticky: DM timeout or misaligned load seen
// BEHAVIOUR
//  - Reset (rst=0, async): wwreg=0, wGPR=0, RF_indata=0, dm_err=0,
//    wait counter=0, FSM=RUN. wb_stall=0 while in reset.
//  - Latency: M-stage values appear on W outputs 1 cycle later (registered).
//  - FSM RUN: each edge latches M stage. Non-load: RF_indata=malu, wwreg=mwreg.
//    Load (mm2reg&mwreg) with dm_ready=1: RF_indata=aligned(mmo), wwreg=1.
//    Load with dm_ready=0: wb_stall=1, W gets bubble (wwreg=0), go WAIT, cnt=1.
//  - FSM WAIT: upstream frozen so M inputs held. wb_stall=~dm_ready & ~timeout.
//    dm_ready=1 -> latch aligned load, go RUN, cnt=0 (stall drops same cycle).
//    cnt==TIMEOUT -> set dm_err, retire load with RF_indata=0, go RUN.
//    Else cnt++, bubble into W.
//  - Alignment (little-endian, off=malu[1:0]): lb/lbu pick byte off, sign/zero
//    extend; lh/lhu pick half off[1], sign/zero extend; lw whole word.
//    Misaligned lw (off!=0) or lh/lhu (off[0]=1): wwreg=0, dm_err set, no stall.
//  - Undefined mltype (101..111) treated as lw.
//  - wGPR==0: wwreg forced 0 (r0 never written); RF_indata still updated.
//  - wb_stall only asserts for loads; mwreg=0 load-class ops never stall.
//  - Reset mid-WAIT: FSM returns to RUN, pending load discarded, no RF write.
//  - dm_err cleared only by reset.
// CONFIGURATION
//  PIPE_WB_RETIRE_CNT_EN defined: adds port retire_cnt out 32, counts cycles
//  with wwreg=1 (after r0 suppression); reset 0, wraps 32'hFFFFFFFF->0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - add r3 (mwreg=1,mm2reg=0,mGPR=3,malu=32'h0000_0011) -> next cycle
//    wwreg=1,wGPR=3,RF_indata=32'h11, wb_stall=0.
//  - lb, malu[1:0]=2, mmo=32'h1280_3456, dm_ready=1 -> RF_indata=32'hFFFF_FF80;
//    lbu same -> 32'h0000_0080; lh off=2 -> 32'h0000_1280.
//  - lw with dm_ready low 3 cycles then high -> wb_stall=1 for 3 cycles, 3
//    bubbles (wwreg=0), then one write with RF_indata=mmo, stall drops.
//  - lw, dm_ready held 0 -> wb_stall drops after TIMEOUT=16 cycles, dm_err=1,
//    RF_indata=0 written to wGPR.
//  - write to r0 (mGPR=0,mwreg=1) -> wwreg=0; lh with malu=32'h1001 ->
//    wwreg=0, dm_err=1, no stall.
//  - rst pulsed low in WAIT -> all outputs 0 asynchronously, no write after
//    release; retire_cnt (if enabled) resets to 0.

Source files
------------

// File: rtl/pipe_wb.sv
// pipe_wb: MEM/WB pipeline register and writeback stage.
// Drives the register-file write port (wwreg / wGPR / RF_indata). The stage
// aligns sub-word loads and waits for a slow data memory. While it waits,
// wb_stall freezes the upstream stages.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   mwreg, mm2reg      M-stage GPR write enable / load indicator
//   mGPR, malu         M-stage destination register / ALU result or address
//   mmo, mltype        raw DM read word / load type (lw, lb, lbu, lh, lhu)
//   dm_ready           DM read data valid this cycle
//   wwreg, wGPR        registered RF write enable / register number
//   RF_indata          registered RF write data
//   wb_stall           combinational upstream freeze request
//   dm_err             sticky DM timeout / misaligned-load flag
//   retire_cnt         count of retired RF writes (PIPE_WB_RETIRE_CNT_EN only)
//
// Optional feature: define PIPE_WB_RETIRE_CNT_EN to add the retire_cnt port.
module pipe_wb #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mGPR,
    input  logic [31:0] malu,
    input  logic [31:0] mmo,
    input  logic [2:0]  mltype,
    input  logic        dm_ready,
    output logic        wwreg,
    output logic [4:0]  wGPR,
    output logic [31:0] RF_indata,
    output logic        wb_stall,
    output logic        dm_err
`ifdef PIPE_WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wwreg_q, wwreg_d;
    logic [REG_W-1:0]    wgpr_q, wgpr_d;
    logic [DATA_W-1:0]   rf_q, rf_d;
    logic                err_q, err_d;
    logic                stall_c;

    logic                is_load;
    logic                wr_ok;
    logic                timeout;
    logic                misaligned;
    logic [1:0]          off;
    logic [DATA_W-1:0]   shifted;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   ld_data;

    // Little-endian sub-word extraction and extension.
    always_comb begin
        off     = malu[1:0];
        shifted = mmo >> {off, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = off[1] ? mmo[31:16] : mmo[15:0];
        case (mltype)
            LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_data = {24'd0, ld_byte};
            LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = mmo;
        endcase
    end

    // Alignment faults; unused type codes behave as lw.
    always_comb begin
        case (mltype)
            LT_LB, LT_LBU: misaligned = 1'b0;
            LT_LH, LT_LHU: misaligned = off[0];
            default:       misaligned = (off != 2'd0);
        endcase
    end

    assign is_load = mm2reg & mwreg;
    assign wr_ok   = (mGPR != 5'd0);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT));

    // Next-state and writeback selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wwreg_d = 1'b0;
        wgpr_d  = mGPR;
        rf_d    = rf_q;
        err_d   = err_q;
        stall_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!is_load) begin
                    rf_d    = malu;
                    wwreg_d = mwreg & wr_ok;
                end else if (misaligned) begin
                    // Faulting load retires without a write and never stalls.
                    rf_d  = ld_data;
                    err_d = 1'b1;
                end else if (dm_ready) begin
                    rf_d    = ld_data;
                    wwreg_d = wr_ok;
                end else begin
                    stall_c = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dm_ready) begin
                    rf_d    = ld_data;
                    wwreg_d = wr_ok;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (timeout) begin
                    // Forced completion: write zero so the pipeline can drain.
                    rf_d    = '0;
                    wwreg_d = wr_ok;
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and W-stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            wwreg_q <= 1'b0;
            wgpr_q  <= '0;
            rf_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wwreg_q <= wwreg_d;
            wgpr_q  <= wgpr_d;
            rf_q    <= rf_d;
            err_q   <= err_d;
        end
    end

`ifdef PIPE_WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Counts cycles with a real RF write; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (wwreg_q) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`endif

    // Stall is held low while reset is asserted.
    assign wb_stall  = stall_c & rst;
    assign wwreg     = wwreg_q;
    assign wGPR      = wgpr_q;
    assign RF_indata = rf_q;
    assign dm_err    = err_q;

endmodule

// File: tb/tb_pipe_wb.sv
// Directed bench for pipe_wb. Each scenario task drives M-stage inputs and
// checks the registered W-stage outputs 1 time unit after the rising edge.
// It checks the combinational stall before each edge.
module tb_pipe_wb;

    logic        clk;
    logic        rst;
    logic        mwreg;
    logic        mm2reg;
    logic [4:0]  mGPR;
    logic [31:0] malu;
    logic [31:0] mmo;
    logic [2:0]  mltype;
    logic        dm_ready;
    logic        wwreg;
    logic [4:0]  wGPR;
    logic [31:0] RF_indata;
    logic        wb_stall;
    logic        dm_err;
`ifdef PIPE_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks;
    int failures;

    pipe_wb #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mGPR      (mGPR),
        .malu      (malu),
        .mmo       (mmo),
        .mltype    (mltype),
        .dm_ready  (dm_ready),
        .wwreg     (wwreg),
        .wGPR      (wGPR),
        .RF_indata (RF_indata),
        .wb_stall  (wb_stall),
        .dm_err    (dm_err)
`ifdef PIPE_WB_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_m(input logic wr, input logic ld, input logic [4:0] gpr,
                         input logic [31:0] alu, input logic [31:0] mo,
                         input logic [2:0] lt, input logic rdy);
        mwreg = wr; mm2reg = ld; mGPR = gpr; malu = alu;
        mmo = mo; mltype = lt; dm_ready = rdy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_m(1'b1, 1'b1, 5'd6, 32'h0, 32'h0, 3'b000, 1'b0);
        checks++;
        if (wb_stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%b exp=0", wb_stall);
        end
        step();
        checks++;
        if ({wwreg, wGPR, RF_indata, dm_err} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs got wwreg=%b wGPR=%0d rf=%h err=%b exp all 0",
                     wwreg, wGPR, RF_indata, dm_err);
        end
        set_m(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b1);
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu();
        set_m(1'b1, 1'b0, 5'd3, 32'h0000_0011, 32'hFFFF_FFFF, 3'b000, 1'b1);
        checks++;
        if (wb_stall !== 1'b0) begin
            failures++; $display("FAIL alu_stall got=%b exp=0", wb_stall);
        end
        step();
        checks++;
        if (wwreg !== 1'b1 || wGPR !== 5'd3 || RF_indata !== 32'h11) begin
            failures++;
            $display("FAIL alu_write got wwreg=%b wGPR=%0d rf=%h exp 1/3/00000011",
                     wwreg, wGPR, RF_indata);
        end
    endtask

    task automatic test_back_to_back();
        set_m(1'b1, 1'b0, 5'd1, 32'h0000_000A, 32'h0, 3'b000, 1'b0);
        step();
        set_m(1'b1, 1'b0, 5'd2, 32'h0000_000B, 32'h0, 3'b000, 1'b0);
        checks++;
        if (wwreg !== 1'b1 || wGPR !== 5'd1 || RF_indata !== 32'hA) begin
            failures++;
            $display("FAIL b2b_first got wwreg=%b wGPR=%0d rf=%h exp 1/1/0000000a",
                     wwreg, wGPR, RF_indata);
        end
        step();
        checks++;
        if (wwreg !== 1'b1 || wGPR !== 5'd2 || RF_indata !== 32'hB) begin
            failures++;
            $display("FAIL b2b_second got wwreg=%b wGPR=%0d rf=%h exp 1/2/0000000b",
                     wwreg, wGPR, RF_indata);
        end
    endtask

    task automatic test_align();
        logic [2:0]  lt   [6];
        logic [31:0] adr  [6];
        logic [31:0] word [6];
        logic [31:0] exp  [6];
        lt[0] = 3'b001; adr[0] = 32'h0000_1002; word[0] = 32'h1280_3456; exp[0] = 32'hFFFF_FF80;
        lt[1] = 3'b010; adr[1] = 32'h0000_1002; word[1] = 32'h1280_3456; exp[1] = 32'h0000_0080;
        lt[2] = 3'b011; adr[2] = 32'h0000_1002; word[2] = 32'h1280_3456; exp[2] = 32'h0000_1280;
        lt[3] = 3'b011; adr[3] = 32'h0000_1000; word[3] = 32'h1280_8456; exp[3] = 32'hFFFF_8456;
        lt[4] = 3'b100; adr[4] = 32'h0000_1000; word[4] = 32'h1280_8456; exp[4] = 32'h0000_8456;
        lt[5] = 3'b111; adr[5] = 32'h0000_1000; word[5] = 32'hCAFE_F00D; exp[5] = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            set_m(1'b1, 1'b1, 5'd10 + 5'(i), adr[i], word[i], lt[i], 1'b1);
            checks++;
            if (wb_stall !== 1'b0) begin
                failures++; $display("FAIL align_stall[%0d] got=%b exp=0", i, wb_stall);
            end
            step();
            checks++;
            if (wwreg !== 1'b1 || wGPR !== 5'd10 + 5'(i) || RF_indata !== exp[i]) begin
                failures++;
                $display("FAIL align[%0d] got wwreg=%b wGPR=%0d rf=%h exp 1/%0d/%h",
                         i, wwreg, wGPR, RF_indata, 10 + i, exp[i]);
            end
        end
    endtask

    task automatic test_wait();
        set_m(1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'hDEAD_BEEF, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wb_stall !== 1'b1) begin
                failures++; $display("FAIL wait_stall[%0d] got=%b exp=1", i, wb_stall);
            end
            step();
            checks++;
            if (wwreg !== 1'b0) begin
                failures++; $display("FAIL wait_bubble[%0d] got wwreg=%b exp=0", i, wwreg);
            end
        end
        dm_ready = 1'b1;
        #1;
        checks++;
        if (wb_stall !== 1'b0) begin
            failures++; $display("FAIL wait_release got=%b exp=0", wb_stall);
        end
        step();
        checks++;
        if (wwreg !== 1'b1 || wGPR !== 5'd7 || RF_indata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wait_write got wwreg=%b wGPR=%0d rf=%h exp 1/7/deadbeef",
                     wwreg, wGPR, RF_indata);
        end
        set_m(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
        checks++;
        if (wb_stall !== 1'b0) begin
            failures++; $display("FAIL wait_after got=%b exp=0", wb_stall);
        end
        step();
    endtask

    task automatic test_r0();
        set_m(1'b1, 1'b0, 5'd0, 32'h0000_0055, 32'h0, 3'b000, 1'b1);
        step();
        checks++;
        if (wwreg !== 1'b0 || RF_indata !== 32'h55) begin
            failures++;
            $display("FAIL r0_write got wwreg=%b rf=%h exp 0/00000055", wwreg, RF_indata);
        end
    endtask

    task automatic test_misaligned();
        checks++;
        if (dm_err !== 1'b0) begin
            failures++; $display("FAIL misalign_pre_err got=%b exp=0", dm_err);
        end
        set_m(1'b1, 1'b1, 5'd5, 32'h0000_1001, 32'h1234_5678, 3'b011, 1'b0);
        checks++;
        if (wb_stall !== 1'b0) begin
            failures++; $display("FAIL misalign_stall got=%b exp=0", wb_stall);
        end
        step();
        checks++;
        if (wwreg !== 1'b0 || dm_err !== 1'b1) begin
            failures++;
            $display("FAIL misalign_lh got wwreg=%b err=%b exp 0/1", wwreg, dm_err);
        end
        set_m(1'b1, 1'b1, 5'd5, 32'h0000_1002, 32'h1234_5678, 3'b000, 1'b1);
        step();
        checks++;
        if (wwreg !== 1'b0) begin
            failures++; $display("FAIL misalign_lw got wwreg=%b exp=0", wwreg);
        end
    endtask

    task automatic test_reset_in_wait();
        set_m(1'b1, 1'b1, 5'd4, 32'h0000_0200, 32'h0BAD_F00D, 3'b000, 1'b0);
        step();
        step();
        checks++;
        if (wb_stall !== 1'b1 || wGPR !== 5'd4) begin
            failures++;
            $display("FAIL rstwait_pre got stall=%b wGPR=%0d exp 1/4", wb_stall, wGPR);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({wwreg, wGPR, RF_indata, dm_err, wb_stall} !== 40'd0) begin
            failures++;
            $display("FAIL rstwait_async got wwreg=%b wGPR=%0d rf=%h err=%b stall=%b exp all 0",
                     wwreg, wGPR, RF_indata, dm_err, wb_stall);
        end
`ifdef PIPE_WB_RETIRE_CNT_EN
        checks++;
        if (retire_cnt !== 32'd0) begin
            failures++; $display("FAIL rstwait_retire got=%0d exp=0", retire_cnt);
        end
`endif
        set_m(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
        step();
        rst = 1'b1;
        step();
        checks++;
        if (wwreg !== 1'b0 || wb_stall !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_post got wwreg=%b stall=%b exp 0/0", wwreg, wb_stall);
        end
    endtask

    task automatic test_timeout();
        int stall_cycles;
        int bad_bubbles;
        stall_cycles = 0;
        bad_bubbles  = 0;
        set_m(1'b1, 1'b1, 5'd9, 32'h0000_0300, 32'h1111_2222, 3'b000, 1'b0);
        for (int i = 0; i < 40 && wb_stall === 1'b1; i++) begin
            stall_cycles++;
            step();
            if (wwreg !== 1'b0) bad_bubbles++;
        end
        checks++;
        if (stall_cycles != 16) begin
            failures++; $display("FAIL timeout_cycles got=%0d exp=16", stall_cycles);
        end
        checks++;
        if (bad_bubbles != 0 || dm_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_bubbles got writes=%0d err=%b exp 0/0", bad_bubbles, dm_err);
        end
        step();
        checks++;
        if (wwreg !== 1'b1 || wGPR !== 5'd9 || RF_indata !== 32'h0 || dm_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_retire got wwreg=%b wGPR=%0d rf=%h err=%b exp 1/9/00000000/1",
                     wwreg, wGPR, RF_indata, dm_err);
        end
        set_m(1'b1, 1'b0, 5'd8, 32'h0000_0077, 32'h0, 3'b000, 1'b1);
        step();
        checks++;
        if (wwreg !== 1'b1 || RF_indata !== 32'h77 || dm_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got wwreg=%b rf=%h err=%b exp 1/00000077/1",
                     wwreg, RF_indata, dm_err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        set_m(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
        test_reset();
        test_alu();
        test_back_to_back();
        test_align();
        test_wait();
        test_r0();
        test_misaligned();
        test_reset_in_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
